fwd_hazard_unit: RTL and testbench

- Parametrised operand-forwarding and hazard unit for the EX stage of the 5-stage RV32 pipeline.
- Generalises EX forwarding to NUM_SRC source operands and XLEN-bit data.
- Sources forwarded, in priority order: ME ALU result, ME link value (JAL/JALR), WB write data, and an optional retired-write register.
- Owns the stall sequencing for load-use hazards (LOAD_LAT cycles) and for multi-cycle EX operations (MC_LAT cycles).

---
 rtl/fwd_hazard_unit_if.sv | 39 +++
 rtl/fwd_hazard_unit.sv | 174 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the EX/ME/WB pipeline and fwd_hazard_unit: operand indices and values in, selected operands and stall controls out.
// Handshake: no valid/ready pairs; each *_valid/*_en qualifies its stage's fields in the same cycle, and stall/me_bubble/mc_done act at the next edge.
interface fwd_hazard_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2
);
    logic                    ex_valid;
    logic                    ex_mc_start;
    logic [5*NUM_SRC-1:0]    ex_rs;
    logic [XLEN*NUM_SRC-1:0] ex_reg;
    logic                    me_valid;
    logic [6:0]              me_opcode;
    logic [4:0]              me_rd;
    logic [XLEN-1:0]         me_alu_res;
    logic [XLEN-1:0]         me_pc4;
    logic                    wb_en;
    logic [4:0]              wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic [XLEN*NUM_SRC-1:0] src_sel;
    logic                    stall;
    logic                    me_bubble;
    logic                    mc_done;
    logic [1:0]              dbg_state;
    logic [3:0]              dbg_cnt;

    modport master (
        output ex_valid, ex_mc_start, ex_rs, ex_reg,
        output me_valid, me_opcode, me_rd, me_alu_res, me_pc4,
        output wb_en, wb_rd, wb_data,
        input  src_sel, stall, me_bubble, mc_done, dbg_state, dbg_cnt
    );

    modport slave (
        input  ex_valid, ex_mc_start, ex_rs, ex_reg,
        input  me_valid, me_opcode, me_rd, me_alu_res, me_pc4,
        input  wb_en, wb_rd, wb_data,
        output src_sel, stall, me_bubble, mc_done, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use and multi-cycle stall sequencing.
// Define FWD_RET_BYPASS_EN to add the retired-write bypass register as the lowest-priority source.
module fwd_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_unit_if.slave bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [3:0] LU_INIT = 4'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
    localparam logic [3:0] MC_INIT = 4'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MC_BUSY  = 2'd2
    } state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;

    logic         w_me_load;
    logic         w_me_link;
    logic         w_me_alu;
    logic [NUM_SRC-1:0] w_lu_src;
    logic         w_lu;
    logic         w_mc_req;
    logic         w_stall;
    logic         w_bubble;
    logic         w_done;
    logic         w_ret_valid;
    logic [4:0]   w_ret_rd;
    logic [XLEN-1:0] w_ret_data;

    assign w_me_load = bus.me_valid && (bus.me_opcode == OP_LOAD);
    assign w_me_link = bus.me_valid && ((bus.me_opcode == OP_JAL) || (bus.me_opcode == OP_JALR));
    assign w_me_alu  = bus.me_valid && !w_me_load && !w_me_link;

`ifdef FWD_RET_BYPASS_EN
    logic            r_ret_valid;
    logic [4:0]      r_ret_rd;
    logic [XLEN-1:0] r_ret_data;

    // Captures regardless of stall: it mirrors the register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret_valid <= 1'b0;
            r_ret_rd    <= 5'd0;
            r_ret_data  <= '0;
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            r_ret_valid <= 1'b1;
            r_ret_rd    <= bus.wb_rd;
            r_ret_data  <= bus.wb_data;
        end
    end

    assign w_ret_valid = r_ret_valid;
    assign w_ret_rd    = r_ret_rd;
    assign w_ret_data  = r_ret_data;
`else
    assign w_ret_valid = 1'b0;
    assign w_ret_rd    = 5'd0;
    assign w_ret_data  = '0;
`endif

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [4:0] w_rs;
        logic       w_nz;
        logic       w_me_match;
        logic       w_wb_match;
        logic       w_ret_match;

        assign w_rs        = bus.ex_rs[5*i +: 5];
        assign w_nz        = (w_rs != 5'd0);
        assign w_me_match  = w_nz && (w_rs == bus.me_rd);
        assign w_wb_match  = w_nz && bus.wb_en && (w_rs == bus.wb_rd);
        assign w_ret_match = w_nz && w_ret_valid && (w_rs == w_ret_rd);
        assign w_lu_src[i] = w_me_match && w_me_load;

        // A load in ME is never an ME-stage source, so load-use suppression falls out here.
        assign bus.src_sel[XLEN*i +: XLEN] =
            (w_me_match && w_me_alu)  ? bus.me_alu_res :
            (w_me_match && w_me_link) ? bus.me_pc4     :
            w_wb_match                ? bus.wb_data    :
            w_ret_match               ? w_ret_data     :
                                        bus.ex_reg[XLEN*i +: XLEN];
    end

    assign w_lu     = bus.ex_valid && (|w_lu_src);
    assign w_mc_req = bus.ex_valid && bus.ex_mc_start;

    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_lu) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_mc_req) begin
                    if (MC_LAT == 1) begin
                        w_done = 1'b1;
                    end else begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
            end
            S_LU_STALL: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            S_MC_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else begin
                    w_done = 1'b1;
                end
            end
            default: begin
                w_stall  = 1'b0;
                w_bubble = 1'b0;
                w_done   = 1'b0;
            end
        endcase
    end

    // Load-use wins over mc_start; EX is held so mc_start is seen again once back in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_lu) begin
                        if (LOAD_LAT > 1) begin
                            r_state <= S_LU_STALL;
                            r_cnt   <= LU_INIT;
                        end
                    end else if (w_mc_req && (MC_LAT > 1)) begin
                        r_state <= S_MC_BUSY;
                        r_cnt   <= MC_INIT;
                    end
                end
                S_LU_STALL, S_MC_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.stall     = w_stall;
    assign bus.me_bubble = w_bubble;
    assign bus.mc_done   = w_done;
    assign bus.dbg_state = r_state;
    assign bus.dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances share one stimulus stream.
// Instance 0: LOAD_LAT=2 MC_LAT=4; instance 1: LOAD_LAT=1 MC_LAT=1; instance 2: LOAD_LAT=1 MC_LAT=3.
module tb_fwd_hazard_unit;
    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int NDUT    = 3;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

`ifdef FWD_RET_BYPASS_EN
    localparam logic [31:0] RET_EXP = 32'h55;
`else
    localparam logic [31:0] RET_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ex_valid;
    logic        ex_mc_start;
    logic [9:0]  ex_rs;
    logic [63:0] ex_reg;
    logic        me_valid;
    logic [6:0]  me_opcode;
    logic [4:0]  me_rd;
    logic [31:0] me_alu_res;
    logic [31:0] me_pc4;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [63:0] src_v    [NDUT];
    logic        stall_v  [NDUT];
    logic        bubble_v [NDUT];
    logic        done_v   [NDUT];
    logic [1:0]  state_v  [NDUT];
    logic [3:0]  cnt_v    [NDUT];

    int n_pass = 0;
    int n_chk  = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus ();

        assign bus.ex_valid    = ex_valid;
        assign bus.ex_mc_start = ex_mc_start;
        assign bus.ex_rs       = ex_rs;
        assign bus.ex_reg      = ex_reg;
        assign bus.me_valid    = me_valid;
        assign bus.me_opcode   = me_opcode;
        assign bus.me_rd       = me_rd;
        assign bus.me_alu_res  = me_alu_res;
        assign bus.me_pc4      = me_pc4;
        assign bus.wb_en       = wb_en;
        assign bus.wb_rd       = wb_rd;
        assign bus.wb_data     = wb_data;

        assign src_v[g]    = bus.src_sel;
        assign stall_v[g]  = bus.stall;
        assign bubble_v[g] = bus.me_bubble;
        assign done_v[g]   = bus.mc_done;
        assign state_v[g]  = bus.dbg_state;
        assign cnt_v[g]    = bus.dbg_cnt;

        fwd_hazard_unit #(
            .XLEN    (XLEN),
            .NUM_SRC (NUM_SRC),
            .LOAD_LAT((g == 0) ? 2 : 1),
            .MC_LAT  ((g == 0) ? 4 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ex_valid    = 1'b0;
        ex_mc_start = 1'b0;
        ex_rs       = 10'd0;
        ex_reg      = {32'hBBBB, 32'hAAAA};
        me_valid    = 1'b0;
        me_opcode   = OP_ADD;
        me_rd       = 5'd0;
        me_alu_res  = 32'd0;
        me_pc4      = 32'd0;
        wb_en       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_state%0d", d), 64'(state_v[d]), 64'd0);
            check($sformatf("rst_stall%0d", d), 64'(stall_v[d]), 64'd0);
            check($sformatf("rst_bubble%0d", d), 64'(bubble_v[d]), 64'd0);
            check($sformatf("rst_done%0d", d), 64'(done_v[d]), 64'd0);
        end
        rst = 1'b0;

        // ME add x5=0x10 feeding both operands
        tick();
        me_valid = 1'b1; me_opcode = OP_ADD; me_rd = 5'd5; me_alu_res = 32'h10;
        ex_valid = 1'b1; ex_rs = {5'd5, 5'd5};
        #1;
        check("me_alu_both", src_v[0], {32'h10, 32'h10});
        check("me_alu_stall", 64'(stall_v[0]), 64'd0);
        check("me_alu_bubble", 64'(bubble_v[0]), 64'd0);

        // ME beats WB on x5; WB supplies x6
        tick();
        ex_rs = {5'd6, 5'd5}; wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
        #1;
        check("me_wb_mix", src_v[0], {32'h66, 32'h10});

        // invalid ME: register file values pass through
        tick();
        me_valid = 1'b0; wb_en = 1'b0; ex_rs = {5'd3, 5'd5};
        #1;
        check("me_invalid", src_v[0], {32'hBBBB, 32'hAAAA});

        // JAL link value
        tick();
        me_valid = 1'b1; me_opcode = OP_JAL; me_rd = 5'd1; me_pc4 = 32'h104; me_alu_res = 32'h999;
        ex_rs = {5'd2, 5'd1};
        #1;
        check("jal_link", src_v[0], {32'hBBBB, 32'h104});

        // JALR link value on operand 1
        tick();
        me_opcode = OP_JALR; me_rd = 5'd2; me_pc4 = 32'h208;
        #1;
        check("jalr_link", src_v[0], {32'h208, 32'hAAAA});

        // x0 never matches ME or WB
        tick();
        me_opcode = OP_ADD; me_rd = 5'd0; me_alu_res = 32'h777;
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h888; ex_rs = {5'd0, 5'd0};
        #1;
        check("x0_passthru", src_v[0], {32'hBBBB, 32'hAAAA});

        // store data operand (rs2) forwarded from ME
        tick();
        wb_en = 1'b0; me_rd = 5'd8; me_alu_res = 32'h80; ex_rs = {5'd8, 5'd3};
        #1;
        check("store_rs2", src_v[0], {32'h80, 32'hAAAA});

        // load match with no valid EX instruction: no hazard
        tick();
        ex_valid = 1'b0; me_opcode = OP_LOAD; me_rd = 5'd7; me_alu_res = 32'h1234;
        ex_rs = {5'd3, 5'd7};
        #1;
        check("lu_ex_invalid_stall", 64'(stall_v[0]), 64'd0);

        // load-use, LOAD_LAT=2 on instance 0
        tick();
        ex_valid = 1'b1;
        #1;
        check("lu_c0_stall", 64'(stall_v[0]), 64'd1);
        check("lu_c0_bubble", 64'(bubble_v[0]), 64'd1);
        check("lu_c0_no_me_fwd", src_v[0], {32'hBBBB, 32'hAAAA});
        check("lu_c0_stall_ll1", 64'(stall_v[1]), 64'd1);
        tick();
        me_valid = 1'b0;
        #1;
        check("lu_c1_stall", 64'(stall_v[0]), 64'd1);
        check("lu_c1_bubble", 64'(bubble_v[0]), 64'd1);
        check("lu_c1_state", 64'(state_v[0]), 64'd1);
        check("lu_c1_stall_ll1", 64'(stall_v[1]), 64'd0);
        tick();
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        #1;
        check("lu_c2_stall", 64'(stall_v[0]), 64'd0);
        check("lu_c2_bubble", 64'(bubble_v[0]), 64'd0);
        check("lu_c2_wb_fwd", src_v[0], {32'hBBBB, 32'hDEAD});

        // multi-cycle op
        tick();
        wb_en = 1'b0; ex_rs = 10'd0; ex_mc_start = 1'b1;
        #1;
        check("mc_c0_stall4", 64'(stall_v[0]), 64'd1);
        check("mc_c0_done4", 64'(done_v[0]), 64'd0);
        check("mc_c0_done1", 64'(done_v[1]), 64'd1);
        check("mc_c0_stall1", 64'(stall_v[1]), 64'd0);
        check("mc_c0_bubble1", 64'(bubble_v[1]), 64'd0);
        check("mc_c0_stall3", 64'(stall_v[2]), 64'd1);
        tick();
        #1;
        check("mc_c1_stall4", 64'(stall_v[0]), 64'd1);
        check("mc_c1_state4", 64'(state_v[0]), 64'd2);
        check("mc_c1_stall3", 64'(stall_v[2]), 64'd1);
        check("mc_c1_done3", 64'(done_v[2]), 64'd0);
        tick();
        #1;
        check("mc_c2_stall4", 64'(stall_v[0]), 64'd1);
        check("mc_c2_done4", 64'(done_v[0]), 64'd0);
        check("mc_c2_stall3", 64'(stall_v[2]), 64'd0);
        check("mc_c2_done3", 64'(done_v[2]), 64'd1);
        tick();
        ex_mc_start = 1'b0;
        #1;
        check("mc_c3_done4", 64'(done_v[0]), 64'd1);
        check("mc_c3_stall4", 64'(stall_v[0]), 64'd0);
        check("mc_c3_bubble4", 64'(bubble_v[0]), 64'd0);
        check("mc_c3_done3", 64'(done_v[2]), 64'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        check("mc_c4_state4", 64'(state_v[0]), 64'd0);

        // load-use together with mc_start (instance 2: LOAD_LAT=1, MC_LAT=3)
        tick();
        ex_valid = 1'b1; ex_mc_start = 1'b1; me_valid = 1'b1; me_opcode = OP_LOAD; me_rd = 5'd7;
        ex_rs = {5'd3, 5'd7};
        #1;
        check("lumc_c0_stall", 64'(stall_v[2]), 64'd1);
        check("lumc_c0_bubble", 64'(bubble_v[2]), 64'd1);
        check("lumc_c0_done", 64'(done_v[2]), 64'd0);
        tick();
        me_valid = 1'b0;
        #1;
        check("lumc_c1_stall", 64'(stall_v[2]), 64'd1);
        check("lumc_c1_state", 64'(state_v[2]), 64'd0);
        tick();
        #1;
        check("lumc_c2_stall", 64'(stall_v[2]), 64'd1);
        check("lumc_c2_state", 64'(state_v[2]), 64'd2);
        tick();
        #1;
        check("lumc_c3_done", 64'(done_v[2]), 64'd1);
        check("lumc_c3_stall", 64'(stall_v[2]), 64'd0);
        check("rstmc_pre_state", 64'(state_v[0]), 64'd2);
        check("rstmc_pre_stall", 64'(stall_v[0]), 64'd1);

        // reset while instance 0 is mid multi-cycle
        rst = 1'b1; ex_mc_start = 1'b0; ex_valid = 1'b0;
        tick();
        #1;
        check("rstmc_stall", 64'(stall_v[0]), 64'd0);
        check("rstmc_state", 64'(state_v[0]), 64'd0);
        check("rstmc_cnt", 64'(cnt_v[0]), 64'd0);

        // retired-write bypass: x9=0x55 written, read next cycle with stale ex_reg
        rst = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        tick();
        wb_en = 1'b0; ex_valid = 1'b1; ex_rs = {5'd3, 5'd9}; ex_reg = {32'hBBBB, 32'h0};
        #1;
        check("ret_bypass", src_v[0], {32'hBBBB, RET_EXP});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
